// File: rtl/dsp_mac_pkg.sv
// Shared state encoding, default widths and pipeline-latency helper for the
// DSP MAC sequencer slice.
package dsp_mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_A_WIDTH   = 18;
  localparam int DEF_B_WIDTH   = 18;
  localparam int DEF_ACC_WIDTH = 48;

  function automatic int pipe_latency(input int areg, input int breg, input int mreg);
    return ((areg > breg) ? areg : breg) + mreg;
  endfunction

endpackage

// File: rtl/dsp_mac_sequencer_if.sv
// Operand/result handshake bundle of the MAC sequencer; master drives operands
// and consumes the result, slave is the sequencer.
interface dsp_mac_sequencer_if
  import dsp_mac_pkg::*;
#(
  parameter int A_WIDTH   = DEF_A_WIDTH,
  parameter int B_WIDTH   = DEF_B_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int CNT_WIDTH = 16
);
  logic                        START;
  logic [CNT_WIDTH-1:0]        LEN;
  logic                        IN_VALID;
  logic                        IN_READY;
  logic signed [A_WIDTH-1:0]   A;
  logic signed [B_WIDTH-1:0]   B;
  logic                        OUT_VALID;
  logic                        OUT_READY;
  logic signed [ACC_WIDTH-1:0] P_OUT;
  logic                        OVF;
  logic                        BUSY;

  modport master (
    output START, LEN, IN_VALID, A, B, OUT_READY,
    input  IN_READY, OUT_VALID, P_OUT, OVF, BUSY
  );

  modport slave (
    input  START, LEN, IN_VALID, A, B, OUT_READY,
    output IN_READY, OUT_VALID, P_OUT, OVF, BUSY
  );
endinterface

// File: rtl/mac_pipe_stage.sv
// Data register with a valid tag; REG=0 turns it into a combinational pass-through.
module mac_pipe_stage #(
  parameter int WIDTH = 18,
  parameter int REG   = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] d,
  input  logic             d_tag,
  output logic [WIDTH-1:0] q,
  output logic             q_tag
);
  if (REG != 0) begin : g_reg
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        q     <= '0;
        q_tag <= 1'b0;
      end else begin
        q     <= d;
        q_tag <= d_tag;
      end
    end
  end else begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = CLK ^ RST;
    assign q     = d;
    assign q_tag = d_tag;
  end
endmodule

// File: rtl/dsp_mac_sequencer.sv
// Streaming MAC sequencer: accepts LEN signed pairs, returns one accumulated word.
// Build option: DSP_MAC_SAT_EN clamps the accumulator on signed overflow instead of wrapping.
//
// state | meaning
// IDLE  | waiting for START
// ACCUM | accepting operand pairs
// FLUSH | draining in-flight products
// DONE  | result held until OUT_READY
module dsp_mac_sequencer
  import dsp_mac_pkg::*;
#(
  parameter int A_WIDTH   = DEF_A_WIDTH,
  parameter int B_WIDTH   = DEF_B_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH,
  parameter int AREG      = 1,
  parameter int BREG      = 1,
  parameter int MREG      = 1,
  parameter int CNT_WIDTH = 16
) (
  input logic                CLK,
  input logic                RST,
  dsp_mac_sequencer_if.slave bus
);
  localparam int OP_LAT  = pipe_latency(AREG, BREG, 0);
  localparam int P_WIDTH = A_WIDTH + B_WIDTH;

  state_t                      state, state_nxt;
  logic                        start_acc, fire, last_beat, pipe_busy;
  logic [CNT_WIDTH-1:0]        len_q, beat_cnt;
  logic [A_WIDTH-1:0]          a_q, a_al;
  logic [B_WIDTH-1:0]          b_q, b_al;
  logic                        a_tag, b_tag, a_al_tag, b_al_tag, m_tag;
  logic signed [P_WIDTH-1:0]   prod;
  logic [P_WIDTH-1:0]          m_q;
  logic signed [ACC_WIDTH-1:0] acc, prod_ext, sum, acc_nxt;
  logic                        ovf, ovf_now;

  assign fire      = bus.IN_VALID && (state == ACCUM);
  assign last_beat = (beat_cnt + CNT_WIDTH'(1)) == len_q;

  mac_pipe_stage #(.WIDTH(A_WIDTH), .REG(AREG)) u_a_reg (
    .CLK(CLK), .RST(RST), .d(bus.A), .d_tag(fire), .q(a_q), .q_tag(a_tag));
  mac_pipe_stage #(.WIDTH(B_WIDTH), .REG(BREG)) u_b_reg (
    .CLK(CLK), .RST(RST), .d(bus.B), .d_tag(fire), .q(b_q), .q_tag(b_tag));

  // The shallower operand path picks up the missing stage so pairs stay aligned.
  mac_pipe_stage #(.WIDTH(A_WIDTH), .REG(OP_LAT - AREG)) u_a_align (
    .CLK(CLK), .RST(RST), .d(a_q), .d_tag(a_tag), .q(a_al), .q_tag(a_al_tag));
  mac_pipe_stage #(.WIDTH(B_WIDTH), .REG(OP_LAT - BREG)) u_b_align (
    .CLK(CLK), .RST(RST), .d(b_q), .d_tag(b_tag), .q(b_al), .q_tag(b_al_tag));

  assign prod = $signed(a_al) * $signed(b_al);

  mac_pipe_stage #(.WIDTH(P_WIDTH), .REG(MREG)) u_m_reg (
    .CLK(CLK), .RST(RST), .d(prod), .d_tag(a_al_tag & b_al_tag), .q(m_q), .q_tag(m_tag));

  assign pipe_busy = a_tag | b_tag | a_al_tag | b_al_tag | m_tag;

  assign prod_ext = ACC_WIDTH'($signed(m_q));
  assign sum      = acc + prod_ext;
  assign ovf_now  = (acc[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                    (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);

`ifdef DSP_MAC_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  assign acc_nxt = !ovf_now ? sum : (acc[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX);
`else
  assign acc_nxt = sum;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    unique case (state)
      IDLE: if (bus.START) begin
        start_acc = 1'b1;
        state_nxt = (bus.LEN == '0) ? DONE : ACCUM;
      end
      ACCUM:   if (fire && last_beat) state_nxt = FLUSH;
      FLUSH:   if (!pipe_busy)        state_nxt = DONE;
      DONE:    if (bus.OUT_READY)     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      len_q    <= '0;
      beat_cnt <= '0;
    end else if (start_acc) begin
      len_q    <= bus.LEN;
      beat_cnt <= '0;
    end else if (fire) begin
      beat_cnt <= beat_cnt + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (start_acc) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (m_tag) begin
      acc <= acc_nxt;
      if (ovf_now) ovf <= 1'b1;
    end
  end

  assign bus.IN_READY  = (state == ACCUM);
  assign bus.OUT_VALID = (state == DONE);
  assign bus.BUSY      = (state != IDLE);
  assign bus.P_OUT     = acc;
  assign bus.OVF       = ovf;
endmodule
